// File: rtl/rf_wb_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_scheduler_pkg
// Shared constants and types for the regfile writeback scheduler:
//   XLEN  - datapath width
//   AW    - register address width
//   NREG  - number of architectural registers (x0 hardwired to zero)
//   X0    - address of the zero register
//   gnt_e - which source owns the regfile write port this cycle
// -----------------------------------------------------------------------------
package rf_wb_scheduler_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  localparam logic [AW-1:0] X0 = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_LU   = 2'd2
  } gnt_e;

endpackage

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Pending-write scoreboard for long-latency destinations. One busy bit per
// architectural register; bit 0 is never set.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   set_en_i / set_idx_i     - mark a register pending at the next posedge
//   clr_en_i / clr_idx_i     - release a register at the next posedge
//   rs1_i, rs2_i, rd_i       - lookup indices
//   rs1_busy_o, rs2_busy_o,
//   rd_busy_o                - combinational lookups of the current state
//   busy_o                   - full busy vector
// -----------------------------------------------------------------------------
module rf_scoreboard
  import rf_wb_scheduler_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en_i,
  input  logic [AW-1:0]   set_idx_i,
  input  logic            clr_en_i,
  input  logic [AW-1:0]   clr_idx_i,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  input  logic [AW-1:0]   rd_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  output logic            rd_busy_o,
  output logic [NREG-1:0] busy_o
);

  localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;

  // Next busy vector: clear first, then set, so a coinciding set wins; x0 forced idle.
  always_comb begin
    set_mask_s = set_en_i ? (ONE_HOT0 << set_idx_i) : {NREG{1'b0}};
    clr_mask_s = clr_en_i ? (ONE_HOT0 << clr_idx_i) : {NREG{1'b0}};
    busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~ONE_HOT0;
  end

  // Busy vector state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= {NREG{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy_o = busy_q[rs1_i];
  assign rs2_busy_o = busy_q[rs2_i];
  assign rd_busy_o  = busy_q[rd_i];
  assign busy_o     = busy_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// -----------------------------------------------------------------------------
// rf_wb_scheduler
// Owns the single regfile write port and shares it between the in-order
// pipeline WB stage (fixed priority) and a long-latency unit (LU). Tracks LU
// destinations in a scoreboard to stall decode on RAW/WAW hazards, and asks
// the pipeline for a WB bubble when the LU has been refused too long.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   wb_valid/wb_rd/wb_data       - pipeline writeback
//   lu_valid/lu_rd/lu_data       - LU writeback request; lu_ready = consumed
//   id_valid/id_rs1/id_rs2/id_rd/
//   id_wen/id_lu                 - decode-stage instruction; id_stall holds it
//   pipe_hold                    - request for wb_valid=0 so the LU can drain
//   WAddr_RF/WD_RF/WrEn_RF       - regfile write port
//   busy                         - scoreboard contents
// -----------------------------------------------------------------------------
module rf_wb_scheduler
  import rf_wb_scheduler_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            lu_valid,
  input  logic [AW-1:0]   lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_wen,
  input  logic            id_lu,
  output logic            id_stall,
  output logic            pipe_hold,
  output logic [AW-1:0]   WAddr_RF,
  output logic [XLEN-1:0] WD_RF,
  output logic            WrEn_RF,
  output logic [NREG-1:0] busy
);

  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_SAT   = 4'd15;

  gnt_e       gnt_s;
  logic [3:0] wait_q;
  logic [3:0] wait_d;
  logic       hold_q;
  logic       hold_d;
  logic       rs1_busy_s;
  logic       rs2_busy_s;
  logic       rd_busy_s;
  logic       issue_s;
  logic       clr_en_s;

  // Write-port arbitration: pipeline first, LU otherwise; nothing granted in reset.
  always_comb begin
    if (rst) begin
      gnt_s = GNT_NONE;
    end else if (wb_valid) begin
      gnt_s = GNT_PIPE;
    end else if (lu_valid) begin
      gnt_s = GNT_LU;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  // Drive the regfile port from the granted source; an rd of x0 suppresses the write.
  always_comb begin
    WAddr_RF = X0;
    WD_RF    = {XLEN{1'b0}};
    WrEn_RF  = 1'b0;
    lu_ready = 1'b0;
    case (gnt_s)
      GNT_PIPE: begin
        WAddr_RF = wb_rd;
        WD_RF    = wb_data;
        WrEn_RF  = (wb_rd != X0);
      end
      GNT_LU: begin
        WAddr_RF = lu_rd;
        WD_RF    = lu_data;
        WrEn_RF  = (lu_rd != X0);
        lu_ready = 1'b1;  // consumed even when targeting x0
      end
      default: begin
        WAddr_RF = X0;
        WD_RF    = {XLEN{1'b0}};
        WrEn_RF  = 1'b0;
        lu_ready = 1'b0;
      end
    endcase
  end

  // Starvation tracking: count refused LU cycles, raise hold at the threshold.
  always_comb begin
    wait_d = wait_q;
    hold_d = hold_q;
    if (gnt_s == GNT_LU) begin
      wait_d = 4'd0;
      hold_d = 1'b0;
    end else if (lu_valid) begin
      if (wait_q != WAIT_SAT) begin
        wait_d = wait_q + 4'd1;
      end else begin
        wait_d = wait_q;
      end
      if (wait_d == MAX_WAIT_L) begin
        hold_d = 1'b1;
      end else begin
        hold_d = hold_q;
      end
    end else begin
      wait_d = wait_q;
      hold_d = hold_q;
    end
  end

  // Starvation counter and hold flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= 4'd0;
      hold_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      hold_q <= hold_d;
    end
  end

  // No bypass from the LU write cycle: a busy source is released one cycle later.
  assign id_stall  = id_valid & ~rst &
                     (hold_q | rs1_busy_s | rs2_busy_s | (id_wen & rd_busy_s));
  assign pipe_hold = hold_q & ~rst;

  assign issue_s  = id_valid & id_lu & id_wen & ~id_stall & (id_rd != X0);
  assign clr_en_s = (gnt_s == GNT_LU) & (lu_rd != X0);

  rf_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (issue_s),
    .set_idx_i  (id_rd),
    .clr_en_i   (clr_en_s),
    .clr_idx_i  (lu_rd),
    .rs1_i      (id_rs1),
    .rs2_i      (id_rs2),
    .rd_i       (id_rd),
    .rs1_busy_o (rs1_busy_s),
    .rs2_busy_o (rs2_busy_s),
    .rd_busy_o  (rd_busy_s),
    .busy_o     (busy)
  );

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
Controller that owns the single regfile write port and shares it between two writeback sources: the in-order pipeline WB stage and a long-latency unit (LU, e.g. load/mul-div).
Keeps a 32-entry pending-write scoreboard for LU destinations and stalls decode on RAW/WAW hazards against them.
Raises a hold request to drain the LU when it has been starved too long.
Sits between the pipeline, the LU and the regfile write inputs (WAddr_RF, WD_RF, WrEn_RF).

Parameters:
XLEN, 32, data width
NREG, 32, architectural registers (x0 hardwired zero)
AW, 5, register address width
MAX_WAIT, 4, LU cycles refused before pipe_hold asserts (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
wb_valid  in  1  pipeline WB has a result this cycle
wb_rd  in  AW  pipeline destination
wb_data  in  XLEN  pipeline result
lu_valid  in  1  LU result waiting
lu_rd  in  AW  LU destination
lu_data  in  XLEN  LU result
lu_ready  out  1  LU result written this cycle
id_valid  in  1  decode holds a valid instruction
id_rs1  in  AW  source 1
id_rs2  in  AW  source 2
id_rd  in  AW  destination
id_wen  in  1  instruction writes rd
id_lu  in  1  instruction issues to LU
id_stall  out  1  hold decode this cycle
pipe_hold  out  1  request bubble into WB next cycle
WAddr_RF  out  AW  regfile write address
WD_RF  out  XLEN  regfile write data
WrEn_RF  out  1  regfile write enable
busy  out  NREG  scoreboard, debug/verification

Behaviour:
- Registered state:
  - busy_q[31:0], with bit 0 constant 0.
  - wait_q, a 4-bit counter.
  - hold_q.
  - All are 0 in any cycle following rst=1.
- All outputs are combinational from state and inputs. While rst=1, WrEn_RF, lu_ready, id_stall and pipe_hold are all 0.
- Write-port arbitration:
  - The pipeline has fixed priority.
  - If wb_valid=1, the port is granted to the pipeline and lu_ready=0.
  - Otherwise, if lu_valid=1, the port is granted to the LU and lu_ready=1.
  - Zero latency: WAddr_RF, WD_RF and WrEn_RF reflect the granted source in the same cycle; the regfile captures on the next posedge.
- x0 handling:
  - A grant whose rd=0 drives WrEn_RF=0.
  - An LU grant with rd=0 still asserts lu_ready (the result is consumed).
  - Idle cycles: WrEn_RF=0, WAddr_RF=0, WD_RF=0.
- Starvation counter:
  - wait_q increments each cycle with lu_valid=1 and lu_ready=0, saturating at 15.
  - wait_q clears on lu_ready.
  - hold_q sets when the increment reaches MAX_WAIT; hold_q clears in the cycle after lu_ready.
  - pipe_hold = hold_q.
  - The pipeline must present wb_valid=0 within one cycle of pipe_hold=1. The LU is then granted automatically.
  - If wb_valid stays 1, the block keeps waiting; there is no error state.
- Scoreboard:
  - An issue occurs when id_valid, id_lu, id_wen, !id_stall and id_rd≠0 all hold; it sets busy_q[id_rd] at the posedge.
  - An LU grant with lu_rd≠0 clears busy_q[lu_rd] at the posedge.
  - Set and clear on the same index cannot coincide, because WAW stalls the issue. If they do coincide, set wins.
- Hazard stall: id_stall = id_valid & (hold_q | busy_q[id_rs1] | busy_q[id_rs2] | (id_wen & busy_q[id_rd])).
  - Index 0 is never busy.
  - No bypass: a source stays stalled in the LU write cycle and is released the following cycle.
- Reset mid-operation:
  - Pending busy bits, wait_q and hold_q are discarded.
  - An LU result presented during rst is not written and not acknowledged.

Decomposition:
- Shared package: XLEN, AW, NREG, X0 constant, and a grant-source enum {GNT_NONE, GNT_PIPE, GNT_LU}.
- One natural sub-module, rf_scoreboard: the busy vector with set/clear ports and three combinational lookups.
- Arbiter and starvation counter stay in the top.

Test Plan:
1. Reset: rst=1 for 2 cycles with wb_valid=1, wb_rd=5, lu_valid=1 -> WrEn_RF=0, lu_ready=0, pipe_hold=0. After release, busy=0.
2. Pipeline writes:
   - wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF -> same cycle WrEn_RF=1, WAddr_RF=5, WD_RF=0xDEADBEEF.
   - wb_rd=0 -> WrEn_RF=0.
3. RAW hazard through an LU load:
   - Issue id_lu=1, id_rd=7 -> busy[7]=1 next cycle.
   - id_rs2=7 -> id_stall=1.
   - lu_valid=1, lu_rd=7, lu_data=0x1234, wb_valid=0 -> lu_ready=1, WrEn_RF=1, WAddr_RF=7. Next cycle busy[7]=0 and id_stall=0.
4. Starvation with MAX_WAIT=4:
   - wb_valid=1 and lu_valid=1 held -> lu_ready=0 for cycles 1-4, pipe_hold=1 from cycle 5, id_stall=1.
   - Drop wb_valid in cycle 5 -> lu_ready=1 in cycle 5, pipe_hold=0 in cycle 6.
5. WAW: with busy[9]=1, present an issue id_lu=1, id_wen=1, id_rd=9 -> id_stall=1 and busy unchanged. After the LU writes x9, the issue proceeds and busy[9]=1 again.
6. Reset mid-operation:
   - Set busy[7] and busy[12], hold lu_valid until pipe_hold=1, then assert rst for 1 cycle.
   - Next cycle: busy=0, pipe_hold=0, wait_q=0. No write occurred during rst.
